fp_mac_dot_seq: RTL and testbench

FP_MAC_DOT_SEQ -- requirements
Module: fp_mac_dot_seq

---
 rtl/fp_mac_dot_seq_if.sv | 29 ++
 rtl/fp_mac_dot_seq.sv | 85 ++++++++
 tb/tb_fp_mac_dot_seq.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mac_dot_seq_if.sv
// Bundles the dot-product sequencer's control, operand, fp_mac and result signals.
// The design drives the slave side; the environment drives the master side.
interface fp_mac_dot_seq_if #(parameter int LEN_W = 8);
    logic             start;
    logic [LEN_W-1:0] vec_len;
    logic [31:0]      init_acc;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic [31:0]      mac_c;
    logic [31:0]      mac_y;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;

    modport master (
        output start, vec_len, init_acc, in_valid, in_a, in_b, mac_y, out_ready,
        input  in_ready, mac_a, mac_b, mac_c, busy, out_valid, out_data
    );

    modport slave (
        input  start, vec_len, init_acc, in_valid, in_a, in_b, mac_y, out_ready,
        output in_ready, mac_a, mac_b, mac_c, busy, out_valid, out_data
    );
endinterface

// File: rtl/fp_mac_dot_seq.sv
// Sequences FP16 pairs through an external MAC_LAT-cycle fp_mac (Y=A*B+C) to form an FP32 dot product.
// One element per MAC_LAT+1 cycles; in_valid low stalls in FETCH, out_ready low holds the result in DONE.
module fp_mac_dot_seq #(
    parameter int MAC_LAT = 3,
    parameter int LEN_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    fp_mac_dot_seq_if.slave bus
);
    localparam int TW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] count_inc;
    logic [31:0]      acc;
    logic [TW-1:0]    timer;
    logic             last;

    // count never exceeds len-1, so the increment cannot wrap even at len = 2^LEN_W-1
    assign count_inc = count + LEN_W'(1);
    assign last      = (count_inc == len);

    assign bus.in_ready  = (state == FETCH);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = acc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start)      state_nxt = (bus.vec_len == '0) ? DONE : FETCH;
            FETCH: if (bus.in_valid)   state_nxt = WAIT;
            WAIT:  if (timer == '0)    state_nxt = last ? DONE : FETCH;
            DONE:  if (bus.out_ready)  state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            len       <= '0;
            count     <= '0;
            timer     <= '0;
            bus.mac_a <= '0;
            bus.mac_b <= '0;
            bus.mac_c <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        len   <= bus.vec_len;
                        acc   <= bus.init_acc;
                        count <= '0;
                    end
                end
                FETCH: begin
                    if (bus.in_valid) begin
                        bus.mac_a <= bus.in_a;
                        bus.mac_b <= bus.in_b;
                        bus.mac_c <= acc;
                        timer     <= TW'(MAC_LAT - 1);
                    end
                end
                WAIT: begin
                    // timer==0 is the edge where fp_mac's result for the held operands is valid
                    if (timer == '0) begin
                        acc   <= bus.mac_y;
                        count <= count_inc;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mac_dot_seq.sv
// Drives random and directed dot products through fp_mac_dot_seq with a behavioural fp_mac
// and compares results, timing and operand registers against a real-arithmetic reference.
module tb_fp_mac_dot_seq;
    localparam int MAC_LAT = 3;
    localparam int LEN_W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   s_edge = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    logic [15:0] a_q[$];
    logic [15:0] b_q[$];
    logic [31:0] y_pipe [0:MAC_LAT-2];

    fp_mac_dot_seq_if #(.LEN_W(LEN_W)) bus ();

    fp_mac_dot_seq #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic real pow2(input int k);
        real p = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) p = p * 2.0;
        else        for (int i = 0; i < -k; i++) p = p / 2.0;
        return p;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        int  e;
        real m;
        e = int'(h[14:10]);
        m = real'(int'(h[9:0])) / 1024.0;
        if (e == 0) m = m * pow2(-14);
        else        m = (1.0 + m) * pow2(e - 15);
        return h[15] ? -m : m;
    endfunction

    function automatic real f2r(input logic [31:0] f);
        int  e;
        real m;
        e = int'(f[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(int'(f[22:0])) / 8388608.0) * pow2(e - 127);
        return f[31] ? -m : m;
    endfunction

    // Stimulus values are chosen so every sum is exact in FP32, making truncation safe here.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [15:0] rnd_h();
        return {1'($urandom_range(0, 1)), 5'($urandom_range(13, 17)),
                2'($urandom_range(0, 3)), 8'h00};
    endfunction

    // Behavioural fp_mac: result for the operands registered at edge k is valid at edge k+MAC_LAT.
    always @(posedge clk) begin
        y_pipe[0] <= r2f(h2r(bus.mac_a) * h2r(bus.mac_b) + f2r(bus.mac_c));
        for (int i = 1; i < MAC_LAT - 1; i++) y_pipe[i] <= y_pipe[i-1];
    end
    assign bus.mac_y = y_pipe[MAC_LAT-2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int n);
        a_q.delete();
        b_q.delete();
        for (int i = 0; i < n; i++) begin
            a_q.push_back(rnd_h());
            b_q.push_back(rnd_h());
        end
    endtask

    function automatic logic [31:0] ref_dot(input int n, input logic [31:0] init);
        real sum = f2r(init);
        for (int i = 0; i < n; i++) sum = sum + h2r(a_q[i]) * h2r(b_q[i]);
        return r2f(sum);
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'h0);
        check({tag, "_busy"},      32'(bus.busy),      32'h0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
        check({tag, "_out_data"},  bus.out_data,       32'h0);
        check({tag, "_mac_a"},     32'(bus.mac_a),     32'h0);
        check({tag, "_mac_b"},     32'(bus.mac_b),     32'h0);
        check({tag, "_mac_c"},     bus.mac_c,          32'h0);
    endtask

    task automatic run_dot(input int n, input logic [31:0] init, input int stall, input int abort_hs,
                           output logic [31:0] res, output int lat, output int rdy_cnt);
        int  idx = 0;
        int  st = 0;
        int  budget = 0;
        bit  rdy_b;
        real part;
        part    = f2r(init);
        res     = 32'h0;
        lat     = 0;
        rdy_cnt = 0;
        bus.vec_len  = LEN_W'(n);
        bus.init_acc = init;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        s_edge    = cyc;
        bus.start = 1'b0;
        while (!bus.out_valid && budget < 4000) begin
            rdy_b = bus.in_ready;
            if (rdy_b) rdy_cnt++;
            bus.in_valid = 1'b0;
            if (rdy_b && idx < n) begin
                if (st < stall) st++;
                else begin
                    bus.in_valid = 1'b1;
                    bus.in_a     = a_q[idx];
                    bus.in_b     = b_q[idx];
                end
            end
            @(posedge clk); #1;
            budget++;
            if (rdy_b && bus.in_valid) begin
                check("mac_a",         32'(bus.mac_a),    32'(a_q[idx]));
                check("mac_b",         32'(bus.mac_b),    32'(b_q[idx]));
                check("mac_c",         bus.mac_c,         r2f(part));
                check("in_ready_wait", 32'(bus.in_ready), 32'h0);
                part = part + h2r(a_q[idx]) * h2r(b_q[idx]);
                idx++;
                st = 0;
                bus.in_valid = 1'b0;
                if (idx == abort_hs) return;
            end else if (rdy_b) begin
                check("stall_hold", 32'(bus.in_ready), 32'h1);
            end
        end
        check("out_valid_reached", 32'(bus.out_valid), 32'h1);
        lat = cyc - s_edge;
        res = bus.out_data;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("out_valid_drop", 32'(bus.out_valid), 32'h0);
        check("busy_idle",      32'(bus.busy),      32'h0);
        bus.out_ready = 1'b0;
    endtask

    task automatic load_directed();
        a_q = '{16'h3C00, 16'h4000, 16'h3800};
        b_q = '{16'h4000, 16'h4000, 16'h4000};
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] exp;
        logic [31:0] held;
        int          lat;
        int          rdy;
        int          n;
        int          stall;

        bus.start     = 1'b0;
        bus.vec_len   = '0;
        bus.init_acc  = 32'h0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 16'h0;
        bus.in_b      = 16'h0;
        bus.out_ready = 1'b0;
        #1;
        check_zero_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // three-element product, no stalls
        load_directed();
        run_dot(3, 32'h0, 0, 0, res, lat, rdy);
        check("dir_data", res, 32'h40E00000);
        check("dir_lat",  32'(lat), 32'(3 * (MAC_LAT + 1)));
        release_out();

        // an empty vector goes straight to DONE on the start edge
        run_dot(0, 32'h3F800000, 0, 0, res, lat, rdy);
        check("empty_data",  res, 32'h3F800000);
        check("empty_lat",   32'(lat), 32'h0);
        check("empty_ready", 32'(rdy), 32'h0);
        release_out();

        // four idle cycles before each pair
        run_dot(3, 32'h0, 4, 0, res, lat, rdy);
        check("stall_data", res, 32'h40E00000);
        check("stall_lat",  32'(lat), 32'(3 * (MAC_LAT + 1) + 12));
        release_out();

        // result held under backpressure while start is pulsed
        fill(5);
        exp = ref_dot(5, 32'h40400000);
        run_dot(5, 32'h40400000, 0, 0, res, lat, rdy);
        check("bp_data", res, exp);
        held = bus.out_data;
        bus.vec_len = LEN_W'(2);
        for (int i = 0; i < 5; i++) begin
            bus.start = 1'b1;
            @(posedge clk); #1;
            check("bp_valid", 32'(bus.out_valid), 32'h1);
            check("bp_hold",  bus.out_data, held);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_exit_valid", 32'(bus.out_valid), 32'h0);
        check("bp_exit_busy",  32'(bus.busy),      32'h0);
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        check("bp_start_ignored", 32'(bus.busy), 32'h0);

        // reset while waiting on the second element
        load_directed();
        run_dot(3, 32'h0, 0, 2, res, lat, rdy);
        check("abort_busy", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        @(posedge clk); #1;
        check("midrst_no_result", 32'(bus.out_valid), 32'h0);
        rst = 1'b0;
        run_dot(3, 32'h0, 0, 0, res, lat, rdy);
        check("post_rst_data", res, 32'h40E00000);
        release_out();

        // random vectors with random stalls
        for (int r = 0; r < 6; r++) begin
            n     = int'($urandom_range(1, 10));
            stall = int'($urandom_range(0, 2));
            fill(n);
            exp = ref_dot(n, r2f(real'(int'($urandom_range(0, 16)) - 8)));
            run_dot(n, r2f(f2r(exp) - (f2r(exp) - f2r(ref_dot(0, exp)))), stall, 0, res, lat, rdy);
            check("rnd_data", res, ref_dot(n, exp));
            check("rnd_lat",  32'(lat), 32'(n * (MAC_LAT + 1 + stall)));
            release_out();
        end

        // longest vector the length field allows
        n = (1 << LEN_W) - 1;
        fill(n);
        exp = ref_dot(n, 32'hC0800000);
        run_dot(n, 32'hC0800000, 0, 0, res, lat, rdy);
        check("max_data", res, exp);
        check("max_lat",  32'(lat), 32'(n * (MAC_LAT + 1)));
        release_out();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
